imem_loader: RTL and testbench

- Program-load writer for the instruction memory that the pipelined 4-thread CPU fetches from.
- Accepts a byte stream from a host-side source over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes the words into the instruction-memory write port at sequential word addresses.
- Holds the CPU core in reset until a complete image has been loaded, then releases it.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/imem_byte_packer.sv | 52 +++++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction-memory side.
// Holds the instruction-memory geometry and the program-loader state encoding.
package cpu_pkg;

    // Instruction-memory geometry (byte address width matches the CPU PC).
    localparam int unsigned IMEM_ADDR_W      = 9;
    localparam int unsigned IMEM_DEPTH_WORDS = 128;
    localparam int unsigned IMEM_CNT_W       = 8;

    // Datapath widths used by the loader.
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;

    // Program-loader states.
    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_WRITE = 3'd2,
        LD_DONE  = 3'd3,
        LD_DRAIN = 3'd4
    } loader_state_e;

endpackage : cpu_pkg

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer for the instruction-memory loader.
// Ports:
//   clk, rstb  - clock, asynchronous active-low reset
//   push       - place byte_in into the current lane and advance the lane
//   clear      - empty the buffer and restart at lane 0 (wins over push)
//   byte_in    - byte to pack
//   word       - registered buffer; unfilled lanes read as zero
//   full_c     - current lane is the top lane (next push completes the word)
module imem_byte_packer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              push,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full_c
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] buf_q, buf_d;

    // Next-state for lane counter and word buffer.
    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        if (clear) begin
            lane_d = '0;
            buf_d  = '0;
        end else if (push) begin
            // Lane n occupies bits [8n+7:8n].
            buf_d[{lane_q, 3'b000} +: BYTE_W] = byte_in;
            lane_d = lane_q + LANE_W'(1);
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lane_q <= '0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

    assign word   = buf_q;
    assign full_c = (lane_q == LANE_W'(3));

endmodule : imem_byte_packer

// File: rtl/imem_loader.sv
// Program loader for the instruction memory of the 4-thread CPU.
// Packs a host byte stream little-endian into 32-bit words, writes them at
// sequential word addresses from 0, and holds the CPU in reset until a full
// image has been loaded.
// Ports:
//   clk, rstb            - clock, asynchronous active-low reset
//   start                - one-cycle pulse, begins a load (ignored while busy)
//   s_valid/s_data/s_last, s_ready - byte stream handshake
//   imem_wen/imem_waddr/imem_wdata - instruction-memory write port
//   busy, done, err_overflow, word_count - status
//   cpu_rstb             - active-low CPU reset, released only when DONE
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = IMEM_ADDR_W,
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int unsigned CNT_W       = IMEM_CNT_W
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [CNT_W-1:0]  word_count,
    output logic              cpu_rstb
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              err_overflow_q, err_overflow_d;
    logic              last_flag_q, last_flag_d;
    logic              drained_q, drained_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_rstb_q, cpu_rstb_d;
    logic              imem_wen_q, imem_wen_d;

    logic              xfer_c;
    logic              pk_push;
    logic              pk_clear;
    logic [WORD_W-1:0] pk_word;
    logic              pk_full_c;

    assign xfer_c = s_valid & s_ready_q;

    imem_byte_packer u_packer (
        .clk     (clk),
        .rstb    (rstb),
        .push    (pk_push),
        .clear   (pk_clear),
        .byte_in (s_data),
        .word    (pk_word),
        .full_c  (pk_full_c)
    );

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        word_count_d   = word_count_q;
        err_overflow_d = err_overflow_q;
        last_flag_d    = last_flag_q;
        drained_d      = drained_q;
        pk_push        = 1'b0;
        pk_clear       = 1'b0;

        case (state_q)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    state_d        = LD_LOAD;
                    addr_d         = '0;
                    word_count_d   = '0;
                    err_overflow_d = 1'b0;
                    drained_d      = 1'b0;
                    pk_clear       = 1'b1;
                end
            end

            LD_LOAD: begin
                if (xfer_c) begin
                    pk_push = 1'b1;
                    if (pk_full_c || s_last) begin
                        last_flag_d = s_last;
                        state_d     = LD_WRITE;
                    end
                end
            end

            LD_WRITE: begin
                addr_d       = addr_q + ADDR_W'(4);
                word_count_d = word_count_q + CNT_W'(1);
                drained_d    = 1'b0;
                pk_clear     = 1'b1;
                if (last_flag_q) begin
                    state_d = LD_DONE;
                end else if ((word_count_q + CNT_W'(1)) == CNT_W'(DEPTH_WORDS)) begin
                    // Memory full; only an immediate end-of-image keeps this clean.
                    state_d        = LD_DRAIN;
                    err_overflow_d = 1'b0;
                end else begin
                    state_d = LD_LOAD;
                end
            end

            LD_DRAIN: begin
                if (xfer_c) begin
                    if (s_last && !drained_q) begin
                        state_d        = LD_DONE;
                        err_overflow_d = 1'b0;
                    end else begin
                        err_overflow_d = 1'b1;
                        drained_d      = 1'b1;
                        if (s_last) begin
                            state_d = LD_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = LD_IDLE;
            end
        endcase

        // Outputs decoded from the next state so they are flop-driven.
        s_ready_d  = (state_d == LD_LOAD) || (state_d == LD_DRAIN);
        busy_d     = (state_d == LD_LOAD) || (state_d == LD_WRITE) ||
                     (state_d == LD_DRAIN);
        done_d     = (state_d == LD_DONE);
        cpu_rstb_d = (state_d == LD_DONE);
        imem_wen_d = (state_d == LD_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= LD_IDLE;
            addr_q         <= '0;
            word_count_q   <= '0;
            err_overflow_q <= 1'b0;
            last_flag_q    <= 1'b0;
            drained_q      <= 1'b0;
            s_ready_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cpu_rstb_q     <= 1'b0;
            imem_wen_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            word_count_q   <= word_count_d;
            err_overflow_q <= err_overflow_d;
            last_flag_q    <= last_flag_d;
            drained_q      <= drained_d;
            s_ready_q      <= s_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cpu_rstb_q     <= cpu_rstb_d;
            imem_wen_q     <= imem_wen_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign imem_wen     = imem_wen_q;
    assign imem_waddr   = addr_q;
    assign imem_wdata   = pk_word;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_overflow_q;
    assign word_count   = word_count_q;
    assign cpu_rstb     = cpu_rstb_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are derived from
// the byte image itself, and a per-cycle monitor compares the write port and
// handshake against them.
module tb_imem_loader;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rstb;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        imem_wen;
    logic [8:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err_overflow;
    logic [7:0]  word_count;
    logic        cpu_rstb;

    int checks = 0;
    int errors = 0;

    logic [7:0] img_q[$];
    wr_t        exp_q[$];
    wr_t        wr_log[$];
    int         n_writes;
    logic [8:0] last_waddr;

    imem_loader dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .imem_wen     (imem_wen),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count),
        .cpu_rstb     (cpu_rstb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: writes against the expected queue, handshake rules.
    always @(negedge clk) begin
        if (rstb) begin
            if (imem_wen) begin
                n_writes++;
                last_waddr = imem_waddr;
                wr_log.push_back({imem_waddr, imem_wdata});
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("waddr", 32'(imem_waddr), 32'(w.addr));
                    chk("wdata", imem_wdata, w.data);
                end
            end
            chk("s_ready_rule", 32'(s_ready), 32'(busy & ~imem_wen));
            chk("cpu_rstb_vs_done", 32'(cpu_rstb), 32'(done));
            if (busy) chk("done_while_busy", 32'(done), 32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_wen"}, 32'(imem_wen), 32'd0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_overflow), 32'd0);
        chk({tag, "_wcount"}, 32'(word_count), 32'd0);
        chk({tag, "_cpu_rstb"}, 32'(cpu_rstb), 32'd0);
    endtask

    task automatic pulse_start();
        n_writes = 0;
        wr_log   = {};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_cpu_rstb", 32'(cpu_rstb), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(s_ready), 32'd1);
        chk("start_wcount", 32'(word_count), 32'd0);
        chk("start_err", 32'(err_overflow), 32'd0);
        chk("start_waddr", 32'(imem_waddr), 32'd0);
    endtask

    // Present one byte until accepted; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!acc && t < 50) begin
            acc = s_ready;
            @(negedge clk);
            t++;
        end
        chk("byte_accepted", 32'(acc), 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Expected writes for a prefix of img_q: packed words, capped at memory depth.
    task automatic expect_words(input int n_bytes, input int n_words);
        for (int k = 0; k < n_words; k++) begin
            logic [31:0] d;
            d = 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (4 * k + b < n_bytes) d[8*b +: 8] = img_q[4*k+b];
            end
            exp_q.push_back({9'(4 * k), d});
        end
    endtask

    task automatic run_load(input int max_gap, input int start_at);
        int n;
        int nw;
        int t;
        logic exp_done;
        n  = img_q.size();
        nw = (n + 3) / 4;
        if (nw > 128) nw = 128;
        exp_done = (n <= 513);
        expect_words(n, nw);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            int gap;
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) @(negedge clk);
            send_byte(img_q[i], i == n - 1);
            if (n > 512 && i == 511) chk("err_before_drain", 32'(err_overflow), 32'd0);
            if (n > 513 && i == 512) chk("err_after_513", 32'(err_overflow), 32'd1);
        end
        if (n <= 512) chk("final_write_cycle", 32'(imem_wen), 32'd1);
        t = 0;
        while (!(done || !busy) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("end_latency", 32'(t), (n <= 512) ? 32'd1 : 32'd0);
        chk("end_done", 32'(done), 32'(exp_done));
        chk("end_cpu_rstb", 32'(cpu_rstb), 32'(exp_done));
        chk("end_err", 32'(err_overflow), 32'(n > 513));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_wcount", 32'(word_count), 32'(nw));
        chk("end_nwrites", 32'(n_writes), 32'(nw));
        chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
        exp_q = {};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        n_writes = 0; last_waddr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstb = 1'b1;
        @(negedge clk);

        // Two full words.
        img_q = {};
        for (int i = 1; i <= 8; i++) img_q.push_back(8'(i));
        run_load(0, -1);
        chk("t1_log_size", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() >= 2) begin
            chk("t1_w0_addr", 32'(wr_log[0].addr), 32'h000);
            chk("t1_w0_data", wr_log[0].data, 32'h04030201);
            chk("t1_w1_addr", 32'(wr_log[1].addr), 32'h004);
            chk("t1_w1_data", wr_log[1].data, 32'h08070605);
        end

        // Partial last word, restarted from DONE.
        img_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        run_load(0, -1);
        if (wr_log.size() >= 2) begin
            chk("t2_w0_data", wr_log[0].data, 32'hDDCCBBAA);
            chk("t2_w1_addr", 32'(wr_log[1].addr), 32'h004);
            chk("t2_w1_data", wr_log[1].data, 32'h00002211);
        end

        // Random gaps, plus a start pulse mid-load that must be ignored.
        img_q = {};
        for (int i = 0; i < 41; i++) img_q.push_back(8'($urandom));
        run_load(3, 5);

        // Exact fit.
        img_q = {};
        for (int i = 0; i < 512; i++) img_q.push_back(8'(i * 7 + 3));
        run_load(0, -1);
        chk("t4_last_addr", 32'(last_waddr), 32'h1FC);

        // Overflow: 520 bytes.
        img_q = {};
        for (int i = 0; i < 520; i++) img_q.push_back(8'(i * 13 + 1));
        run_load(0, -1);
        chk("t5_last_addr", 32'(last_waddr), 32'h1FC);

        // Async reset after two bytes of the third word.
        img_q = {};
        for (int i = 0; i < 10; i++) img_q.push_back(8'(8'h40 + i));
        expect_words(8, 2);
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(img_q[i], 1'b0);
        #2 rstb = 1'b0;
        #1 check_all_zero("midreset");
        chk("midreset_exp_empty", 32'(exp_q.size()), 32'd0);
        exp_q = {};
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        // Fresh load after the abandoned one.
        img_q = {8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
        run_load(0, -1);
        if (wr_log.size() >= 2) begin
            chk("t7_w0_addr", 32'(wr_log[0].addr), 32'h000);
            chk("t7_w1_data", wr_log[1].data, 32'h0000009E);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
